// File: rtl/add_pkg.sv
// Shared definitions for the pipelined adder/subtractor: op encodings,
// legal parameter limits and the transfer counter width.
package add_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  localparam int WIDTH_MIN  = 2;
  localparam int WIDTH_MAX  = 64;
  localparam int STAGES_MIN = 1;
  localparam int STAGES_MAX = 8;
  localparam int COUNT_W    = 16;

endpackage

// File: rtl/add_pipe_stage.sv
// One pipeline slot: registered payload plus valid bit. The slot loads when
// it is empty or when the slot downstream frees up this cycle, so bubbles
// collapse instead of propagating.
module add_pipe_stage #(
  parameter int DW = 34
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          next_load,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          valid,
  output logic [DW-1:0] data
);

  logic load;

  assign load = ~valid | next_load;

  // Slot register; payload only captured when a real item arrives so an
  // empty load does not disturb the held value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= in_valid;
      if (in_valid) begin
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/add_pipe.sv
// Pipelined add/subtract with optional signed saturation. Arithmetic sits in
// front of stage 0; the remaining stages just move {ovf, carry, result}
// forward. Backpressure is combinational from out_ready to in_ready.
module add_pipe
  import add_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2,
  parameter int SAT    = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               op,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out,
  output logic               carry,
  output logic               ovf,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COUNT_W-1:0] count
);

  localparam int DW = WIDTH + 2;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("add_pipe: WIDTH out of range");
  end
  if (STAGES < STAGES_MIN || STAGES > STAGES_MAX) begin : g_bad_stages
    $error("add_pipe: STAGES out of range");
  end
  if (SAT != 0 && SAT != 1) begin : g_bad_sat
    $error("add_pipe: SAT must be 0 or 1");
  end

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum;
  logic             sum_ovf;
  logic [WIDTH-1:0] sum_res;
  logic [DW-1:0]    front_data;

  logic [STAGES-1:0] stg_valid;
  logic [DW-1:0]     stg_data [STAGES];
  logic [STAGES-1:0] next_load;

  // Front-end arithmetic: subtraction is a + ~b + 1 so carry=1 means no borrow.
  always_comb begin
    b_eff   = (op == OP_SUB) ? ~b : b;
    sum     = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, op};
    sum_ovf = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    sum_res = sum[WIDTH-1:0];
    if (SAT != 0 && sum_ovf) begin
      sum_res = a[WIDTH-1] ? SMIN : SMAX;
    end
  end

  assign front_data = {sum_ovf, sum[WIDTH], sum_res};

  // Downstream-free signal per stage, derived from registered valids only so
  // there is no combinational loop through the stage instances.
  always_comb begin
    next_load = '0;
    next_load[STAGES-1] = out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      next_load[k] = next_load[k+1] | ~stg_valid[k+1];
    end
  end

  assign in_ready = ~stg_valid[0] | next_load[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic          sv;
    logic [DW-1:0] sd;

    if (k == 0) begin : g_first
      assign sv = in_valid;
      assign sd = front_data;
    end else begin : g_rest
      assign sv = stg_valid[k-1];
      assign sd = stg_data[k-1];
    end

    add_pipe_stage #(.DW(DW)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .next_load (next_load[k]),
      .in_valid  (sv),
      .in_data   (sd),
      .valid     (stg_valid[k]),
      .data      (stg_data[k])
    );
  end

  assign out_valid           = stg_valid[STAGES-1];
  assign {ovf, carry, out}   = stg_data[STAGES-1];

  // Completed output transfers, free-running wrap at 16 bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (out_valid && out_ready) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: tb/tb_add_pipe.sv
// Scoreboard bench for add_pipe: two instances share stimulus
// (STAGES=2/SAT=0 and STAGES=3/SAT=1); each has its own expected-result queue.
module tb_add_pipe;

  typedef struct {
    logic [31:0] res;
    logic        carry;
    logic        ovf;
    int          cyc;
    bit          lat;
  } exp_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic        op;
  } vec_t;

  localparam longint SMAX_L = 64'sd2147483647;
  localparam longint SMIN_L = -SMAX_L - 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] a, b;
  logic        op, in_valid, out_ready;

  logic [1:0]  in_rdy, o_valid, o_carry, o_ovf;
  logic [31:0] o_out [2];
  logic [15:0] o_cnt [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   lat_mode = 0;
  exp_t sb [2][$];
  int   acc [2];
  bit   stall_prev [2];
  logic [33:0] hold [2];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  add_pipe #(.WIDTH(32), .STAGES(2), .SAT(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op),
    .in_valid(in_valid), .in_ready(in_rdy[0]),
    .out(o_out[0]), .carry(o_carry[0]), .ovf(o_ovf[0]),
    .out_valid(o_valid[0]), .out_ready(out_ready), .count(o_cnt[0])
  );

  add_pipe #(.WIDTH(32), .STAGES(3), .SAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op),
    .in_valid(in_valid), .in_ready(in_rdy[1]),
    .out(o_out[1]), .carry(o_carry[1]), .ovf(o_ovf[1]),
    .out_valid(o_valid[1]), .out_ready(out_ready), .count(o_cnt[1])
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: true signed/unsigned results in 64-bit arithmetic.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic o, input bit sat);
    exp_t        e;
    longint      sx, sy, r;
    logic [63:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r  = o ? (sx - sy) : (sx + sy);
    u  = {32'd0, x} + {32'd0, y};
    e.ovf   = (r > SMAX_L) || (r < SMIN_L);
    e.carry = o ? (x >= y) : u[32];
    e.res   = r[31:0];
    if (sat && e.ovf) e.res = (r > 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
    e.cyc = 0;
    e.lat = 0;
    return e;
  endfunction

  // Monitor: push on input transfers, pop and compare on output transfers.
  always @(negedge clk) begin
    exp_t e;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        sb[d].delete();
        acc[d] = 0;
        stall_prev[d] = 0;
      end else begin
        if (in_valid && in_rdy[d]) begin
          e = model(a, b, op, d == 1);
          e.cyc = cyc;
          e.lat = lat_mode;
          sb[d].push_back(e);
          acc[d]++;
        end
        if (stall_prev[d])
          check($sformatf("d%0d hold", d), {o_valid[d], o_out[d], o_carry[d], o_ovf[d]},
                {1'b1, hold[d]});
        if (o_valid[d] && out_ready) begin
          check($sformatf("d%0d unexpected output", d), sb[d].size() > 0, 1);
          if (sb[d].size() > 0) begin
            e = sb[d].pop_front();
            check($sformatf("d%0d out", d), o_out[d], e.res);
            check($sformatf("d%0d carry", d), o_carry[d], e.carry);
            check($sformatf("d%0d ovf", d), o_ovf[d], e.ovf);
            if (e.lat) check($sformatf("d%0d latency", d), cyc - e.cyc, (d == 0) ? 2 : 3);
          end
        end
        stall_prev[d] = o_valid[d] && !out_ready;
        hold[d] = {o_out[d], o_carry[d], o_ovf[d]};
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    in_valid  = 0;
    out_ready = 1;
    while ((sb[0].size() != 0 || sb[1].size() != 0) && n < 300) begin
      step();
      n++;
    end
    @(negedge clk);
    check({tag, " drain"}, sb[0].size() + sb[1].size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [5];
    int   base [2];
    int   n;
    vecs[0] = '{a: 32'h7FFF_FFFF, b: 32'h1, op: 1'b0};
    vecs[1] = '{a: 32'hFFFF_FFFF, b: 32'h1, op: 1'b0};
    vecs[2] = '{a: 32'h8000_0000, b: 32'h1, op: 1'b1};
    vecs[3] = '{a: 32'h3,         b: 32'h5, op: 1'b1};
    vecs[4] = '{a: 32'h0,         b: 32'h0, op: 1'b1};

    rst_n = 1; a = 0; b = 0; op = 0; in_valid = 0; out_ready = 1;
    #3 rst_n = 0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d rst out_valid", d), o_valid[d], 0);
      check($sformatf("d%0d rst count", d), o_cnt[d], 0);
      check($sformatf("d%0d rst data", d), {o_out[d], o_carry[d], o_ovf[d]}, 0);
    end
    step(); step();
    rst_n = 1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check($sformatf("d%0d in_ready after rst", d), in_rdy[d], 1);

    // Back-to-back a=5, b=0..9 with latency checking.
    step();
    lat_mode = 1;
    for (int i = 0; i < 10; i++) begin
      a = 5; b = i; op = 0; in_valid = 1;
      step();
    end
    in_valid = 0;
    drain("seq");
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d seq accepted", d), acc[d], 10);
      check($sformatf("d%0d seq count", d), o_cnt[d], 10);
    end

    // Overflow / carry / saturation corner vectors.
    step();
    foreach (vecs[i]) begin
      a = vecs[i].a; b = vecs[i].b; op = vecs[i].op; in_valid = 1;
      step();
    end
    in_valid = 0;
    drain("corner");
    lat_mode = 0;

    // Output stalled: each instance fills to its depth, then refuses.
    step();
    base[0] = acc[0]; base[1] = acc[1];
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      a = 100 + i; b = i; op = i % 2; in_valid = 1;
      step();
    end
    @(negedge clk);
    check("d0 stall accepted", acc[0] - base[0], 2);
    check("d1 stall accepted", acc[1] - base[1], 3);
    check("d0 stall in_ready", in_rdy[0], 0);
    check("d1 stall in_ready", in_rdy[1], 0);
    step();
    drain("stall");

    // Reset with two results in flight.
    step();
    out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      a = 40 + i; b = 7; op = 0; in_valid = 1;
      step();
    end
    in_valid = 0;
    step();
    rst_n = 0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d midrst out_valid", d), o_valid[d], 0);
      check($sformatf("d%0d midrst count", d), o_cnt[d], 0);
    end
    step(); step();
    rst_n = 1;
    out_ready = 1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) check($sformatf("d%0d in_ready after midrst", d), in_rdy[d], 1);
    step();
    a = 1; b = 2; op = 0; in_valid = 1;
    step();
    in_valid = 0;
    drain("post reset");
    for (int d = 0; d < 2; d++) check($sformatf("d%0d post reset count", d), o_cnt[d], 1);

    // Random traffic with random backpressure.
    base[0] = acc[0]; base[1] = acc[1];
    n = 0;
    while ((acc[0] - base[0] < 1000 || acc[1] - base[1] < 1000) && n < 20000) begin
      case ($urandom_range(0, 7))
        0: a = 32'h7FFF_FFFF;
        1: a = 32'h8000_0000;
        2: a = 32'hFFFF_FFFF;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'h7FFF_FFFF;
        1: b = 32'h8000_0000;
        2: b = 32'h1;
        default: b = $urandom;
      endcase
      op        = 1'($urandom_range(0, 1));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      step();
      n++;
    end
    check("random budget", n < 20000, 1);
    drain("random");
    for (int d = 0; d < 2; d++) begin
      check($sformatf("d%0d random min transfers", d), acc[d] >= 1001, 1);
      check($sformatf("d%0d random count", d), o_cnt[d], 16'(acc[d]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
